// File: rtl/vga_font_loader_if.sv
// Host/font-RAM side bundle for vga_font_loader.
// master: host and display arbiter (drive data/valid/lock).
// slave:  the loader itself.
interface vga_font_loader_if;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic        i_lock;
    logic        o_wr_en;
    logic [11:0] o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_data, i_valid, i_lock,
        input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err
    );

    modport slave (
        input  i_data, i_valid, i_lock,
        output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err
    );
endinterface

// File: rtl/vga_font_loader.sv
// vga_font_loader: turns a framed host byte stream into font RAM writes
// at address {char_code, row}. Frame: header, char code, 16 row bytes.
// Optional feature macro: VGA_FONT_LOADER_BURST_EN (multi-glyph frames
// opened by HDR_BURST followed by a glyph count; 0 means 256).
module vga_font_loader #(
    parameter logic [7:0] HDR_GLYPH = 8'h46,
    parameter logic [7:0] HDR_BURST = 8'h42
) (
    input  logic               i_clk,
    input  logic               i_rst,
    vga_font_loader_if.slave   bus
);

`ifdef VGA_FONT_LOADER_BURST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CNT = 2'd1, CHAR = 2'd2, DATA = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CHAR = 2'd2, DATA = 2'd3} state_t;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  char_reg, char_next;
    logic [3:0]  row_reg, row_next;
    logic        wr_en_reg, wr_en_next;
    logic [11:0] wr_addr_reg, wr_addr_next;
    logic [7:0]  wr_data_reg, wr_data_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
`ifdef VGA_FONT_LOADER_BURST_EN
    // Glyphs still to be written after the current one.
    logic [7:0]  cnt_reg, cnt_next;
`endif

    logic accept;

    // Ready is purely combinational so a lock stalls the very next edge.
    assign bus.o_ready = !bus.i_lock && !i_rst;
    assign accept      = bus.i_valid && bus.o_ready;

    assign bus.o_wr_en   = wr_en_reg;
    assign bus.o_wr_addr = wr_addr_reg;
    assign bus.o_wr_data = wr_data_reg;
    assign bus.o_busy    = (state_reg != IDLE);
    assign bus.o_done    = done_reg;
    assign bus.o_err     = err_reg;

    // State and registered output update; reset abandons any frame in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            char_reg    <= 8'd0;
            row_reg     <= 4'd0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 12'd0;
            wr_data_reg <= 8'd0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
`ifdef VGA_FONT_LOADER_BURST_EN
            cnt_reg     <= 8'd0;
`endif
        end else begin
            state_reg   <= state_next;
            char_reg    <= char_next;
            row_reg     <= row_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
`ifdef VGA_FONT_LOADER_BURST_EN
            cnt_reg     <= cnt_next;
`endif
        end
    end

    // Frame parser: every transition and write happens only on an accept.
    always_comb begin
        state_next   = state_reg;
        char_next    = char_reg;
        row_next     = row_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
`ifdef VGA_FONT_LOADER_BURST_EN
        cnt_next     = cnt_reg;
`endif
        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_data == HDR_GLYPH) begin
                        state_next = CHAR;
`ifdef VGA_FONT_LOADER_BURST_EN
                        cnt_next   = 8'd0;
                    end else if (bus.i_data == HDR_BURST) begin
                        state_next = CNT;
`else
                    end else if (bus.i_data == HDR_BURST) begin
                        // Multi-glyph frames are not available in this build.
                        err_next   = 1'b1;
`endif
                    end else begin
                        err_next   = 1'b1;
                    end
                end
`ifdef VGA_FONT_LOADER_BURST_EN
                CNT: begin
                    // n-1 remaining after the first glyph; n = 0 wraps to 255 (256 glyphs).
                    cnt_next   = bus.i_data - 8'd1;
                    state_next = CHAR;
                end
`endif
                CHAR: begin
                    char_next  = bus.i_data;
                    row_next   = 4'd0;
                    state_next = DATA;
                end
                DATA: begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = {char_reg, row_reg};
                    wr_data_next = bus.i_data;
                    row_next     = row_reg + 4'd1;
                    if (row_reg == 4'hF) begin
`ifdef VGA_FONT_LOADER_BURST_EN
                        if (cnt_reg == 8'd0) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            cnt_next   = cnt_reg - 8'd1;
                            char_next  = char_reg + 8'd1;
                        end
`else
                        done_next  = 1'b1;
                        state_next = IDLE;
`endif
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_font_loader.sv
// Self-checking bench for vga_font_loader: reset state, table of frames,
// hand-written timing/lock/reset/burst sequences, then randomized frames
// with random lock and valid gaps against a font-RAM reference model.
module tb_vga_font_loader;

    localparam logic [7:0] HDR_G = 8'h46;
    localparam logic [7:0] HDR_B = 8'h42;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_font_loader_if bus();

    vga_font_loader #(.HDR_GLYPH(HDR_G), .HDR_BURST(HDR_B)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- monitor (samples 1 time unit after the rising edge)
    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        logic        done;
        int          t;
    } wr_t;

    wr_t        wq[$];
    int         cyc = 0;
    int         done_cnt = 0, err_cnt = 0, busy_cycles = 0, ready_low = 0;
    int         stray_done = 0, ready_bad = 0;
    logic [7:0] font_ram [4096];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.o_ready !== (!bus.i_lock && !rst)) ready_bad++;
        if (!rst) begin
            if (bus.o_wr_en) begin
                wq.push_back('{bus.o_wr_addr, bus.o_wr_data, bus.o_done, cyc});
                font_ram[bus.o_wr_addr] = bus.o_wr_data;
            end
            if (bus.o_done) done_cnt++;
            if (bus.o_done && !bus.o_wr_en) stray_done++;
            if (bus.o_err) err_cnt++;
            if (bus.o_busy) busy_cycles++;
            if (!bus.o_ready) ready_low++;
        end
    end

    // ---------------- lock driver (only writer of i_lock)
    int lock_req_total = 0;   // written by main sequence only
    int lock_granted   = 0;   // written here only
    bit rand_lock      = 1'b0;
    initial begin
        bus.i_lock = 1'b0;
        forever begin
            @(negedge clk);
            if (lock_granted < lock_req_total) begin
                bus.i_lock = 1'b1;
                lock_granted++;
            end else if (rand_lock) begin
                bus.i_lock = ($urandom_range(0, 3) == 0);
            end else begin
                bus.i_lock = 1'b0;
            end
        end
    end

    // ---------------- reference model: font RAM contents from the frame rules
    logic [7:0] model_ram   [4096];
    bit         model_known [4096];

    function automatic logic [7:0] row_byte(input logic [7:0] seed, input logic [7:0] mul, input int r);
        logic [7:0] rr;
        rr = r[7:0];
        return seed + mul * rr;
    endfunction

    // ---------------- stimulus helpers
    bit gaps_en = 1'b0;

    task automatic send(input logic [7:0] b);
        int  n = 0;
        bit  took = 1'b0;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            bus.i_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        while (!took && n < 200) begin
            @(posedge clk);
            took = bus.o_ready;
            n++;
            @(negedge clk);
        end
        chk("accept_within_budget", {31'd0, took}, 32'd1);
    endtask

    task automatic send_data(input logic [7:0] seed, input logic [7:0] mul, input int n);
        for (int r = 0; r < n; r++) send(row_byte(seed, mul, r));
    endtask

    task automatic drain();
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_mon();
        wq.delete();
        done_cnt = 0; err_cnt = 0; busy_cycles = 0; ready_low = 0;
    endtask

    // Expected: n writes from start_addr upward (12-bit wrap), one done on the last.
    task automatic check_writes(input string name, input logic [11:0] start_addr,
                                input logic [7:0] seed, input logic [7:0] mul, input int n);
        int bad = 0;
        logic [11:0] a;
        chk({name, "_count"}, wq.size(), n);
        for (int i = 0; i < n; i++) begin
            a = start_addr + i[11:0];
            model_ram[a]   = row_byte(seed, mul, i);
            model_known[a] = 1'b1;
            if (i < wq.size()) begin
                if (wq[i].addr !== a || wq[i].data !== row_byte(seed, mul, i)) bad++;
                if (wq[i].done !== (i == n - 1)) bad++;
            end
        end
        chk({name, "_addr_data_bad"}, bad, 0);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_err_cnt"}, err_cnt, 0);
    endtask

    // ---------------- table of single-frame vectors
    typedef struct {
        logic [7:0] hdr;
        logic [7:0] ch;
        int         exp_writes;
        int         exp_err;
        int         exp_done;
        int         exp_busy;
    } vec_t;

    vec_t vec [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        for (int a = 0; a < 4096; a++) begin
            font_ram[a] = 8'h00; model_ram[a] = 8'h00; model_known[a] = 1'b0;
        end

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en",   {31'd0, bus.o_wr_en}, 32'd0);
        chk("rst_wr_addr", {20'd0, bus.o_wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, bus.o_wr_data}, 32'd0);
        chk("rst_busy",    {31'd0, bus.o_busy}, 32'd0);
        chk("rst_done",    {31'd0, bus.o_done}, 32'd0);
        chk("rst_err",     {31'd0, bus.o_err}, 32'd0);
        chk("rst_ready",   {31'd0, bus.o_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, bus.o_ready}, 32'd1);
        @(negedge clk);

        // ---- scenario: 46, 41, 00..0F back to back
        clear_mon();
        send(HDR_G); send(8'h41); send_data(8'h00, 8'h01, 16);
        drain();
        check_writes("glyph41", 12'h410, 8'h00, 8'h01, 16);
        chk("glyph41_busy_cycles", busy_cycles, 17);
        if (wq.size() == 16) chk("glyph41_one_per_cycle", wq[15].t - wq[0].t, 15);

        // ---- table-driven frames (header 0x55 then frame 0x20, etc.)
        vec[0] = '{8'h55, 8'h00, 0,  1, 0, 0};
        vec[1] = '{HDR_G, 8'h20, 16, 0, 1, 17};
        vec[2] = '{8'h00, 8'h00, 0,  1, 0, 0};
        vec[3] = '{8'hFF, 8'h00, 0,  1, 0, 0};
        vec[4] = '{HDR_G, 8'hFF, 16, 0, 1, 17};
        vec[5] = '{HDR_G, 8'h00, 16, 0, 1, 17};
        vec[6] = '{8'h47, 8'h00, 0,  1, 0, 0};
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            send(vec[v].hdr);
            if (vec[v].exp_writes > 0) begin
                send(vec[v].ch);
                send_data(vec[v].ch, 8'h03, 16);
            end
            drain();
            chk($sformatf("vec%0d_writes", v), wq.size(), vec[v].exp_writes);
            chk($sformatf("vec%0d_err", v), err_cnt, vec[v].exp_err);
            chk($sformatf("vec%0d_done", v), done_cnt, vec[v].exp_done);
            chk($sformatf("vec%0d_busy", v), busy_cycles, vec[v].exp_busy);
            if (vec[v].exp_writes > 0)
                check_writes($sformatf("vec%0d", v), {vec[v].ch, 4'h0}, vec[v].ch, 8'h03, 16);
        end

        // ---- lock held 5 cycles while row 7 is pending
        clear_mon();
        fork
            begin
                send(HDR_G); send(8'h41); send_data(8'h00, 8'h01, 16);
            end
            begin
                n = 0;
                while (wq.size() < 7 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                lock_req_total = lock_req_total + 5;
            end
        join
        drain();
        check_writes("lock41", 12'h410, 8'h00, 8'h01, 16);
        chk("lock_ready_low_cycles", ready_low, 5);
        chk("lock_busy_cycles", busy_cycles, 22);

        // ---- reset after row 9 of glyph 0x30
        clear_mon();
        send(HDR_G); send(8'h30); send_data(8'h80, 8'h05, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_wr_en", {31'd0, bus.o_wr_en}, 32'd0);
        chk("midrst_busy",  {31'd0, bus.o_busy}, 32'd0);
        chk("midrst_addr_data", {12'd0, bus.o_wr_addr, bus.o_wr_data}, 32'd0);
        chk("midrst_done_err", {30'd0, bus.o_done, bus.o_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_valid = 1'b0;
        drain();
        chk("midrst_writes_before", wq.size(), 10);
        chk("midrst_no_done", done_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            model_ram[{8'h30, i[3:0]}]   = row_byte(8'h80, 8'h05, i);
            model_known[{8'h30, i[3:0]}] = 1'b1;
        end
        clear_mon();
        send(HDR_G); send(8'h31); send_data(8'h11, 8'h07, 16);
        drain();
        check_writes("after_rst31", 12'h310, 8'h11, 8'h07, 16);

`ifdef VGA_FONT_LOADER_BURST_EN
        // ---- burst: 42, 02, FF, 32 bytes -> FF0..FFF then 000..00F
        clear_mon();
        send(HDR_B); send(8'h02); send(8'hFF); send_data(8'h09, 8'h01, 32);
        drain();
        check_writes("burst_wrap", 12'hFF0, 8'h09, 8'h01, 32);
        chk("burst_busy_cycles", busy_cycles, 34);
`else
        // ---- burst header rejected when burst frames are not built
        clear_mon();
        send(HDR_B);
        drain();
        chk("burst_hdr_err", err_cnt, 1);
        chk("burst_hdr_writes", wq.size(), 0);
        chk("burst_hdr_busy", busy_cycles, 0);
`endif

        // ---- randomized frames with random lock and valid gaps
        rand_lock = 1'b1;
        gaps_en   = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] b, ch, seed, mul;
            clear_mon();
            if ($urandom_range(0, 4) == 0) begin
                b = 8'($urandom);
                if (b == HDR_G || b == HDR_B) b = 8'h55;
                send(b);
                drain();
                chk($sformatf("rand%0d_bad_err", f), err_cnt, 1);
                chk($sformatf("rand%0d_bad_writes", f), wq.size(), 0);
            end else begin
                ch   = 8'($urandom);
                seed = 8'($urandom);
                mul  = 8'($urandom) | 8'h01;
                send(HDR_G); send(ch); send_data(seed, mul, 16);
                drain();
                check_writes($sformatf("rand%0d", f), {ch, 4'h0}, seed, mul, 16);
            end
        end
        rand_lock = 1'b0;
        gaps_en   = 1'b0;
        drain();

        // ---- global invariants and final font RAM contents
        begin
            int bad = 0;
            for (int a = 0; a < 4096; a++)
                if (model_known[a] && font_ram[a] !== model_ram[a]) bad++;
            chk("font_ram_contents", bad, 0);
        end
        chk("done_without_write", stray_done, 0);
        chk("ready_rule", ready_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
